// File: rtl/mesm6_pkg.sv
// Shared definitions for the MESM-6 peripheral-bus to Avalon-MM bridge.
package mesm6_pkg;

    localparam int MESM_WORD_W = 48;
    localparam int MESM_ADDR_W = 15;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE
    } bridge_state_t;

    // Number of Avalon beats needed to move one 48-bit MESM word.
    function automatic int beats_for(input int dw);
        return (MESM_WORD_W + dw - 1) / dw;
    endfunction

endpackage

// File: rtl/mesm6_bridge_wdog.sv
// Stall watchdog: counts consecutive stalled cycles since the last load and
// flags the cycle in which the LIMIT-th stall occurs.
module mesm6_bridge_wdog #(
    parameter int LIMIT = 1023
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic stall_i,
    output logic expired_o
);

    logic [15:0] cnt_q, cnt_d;

    // Terminal when this stall would be the LIMIT-th one in a row.
    assign expired_o = stall_i && (cnt_q == 16'(LIMIT - 1));

    // Restart on every new beat, otherwise count stalled cycles.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = '0;
        else if (stall_i)
            cnt_d = cnt_q + 16'd1;
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/mesm6_avalon_bridge.sv
// MESM-6 peripheral bus (48-bit word) to Avalon-MM master bridge.
// Each access is split into BEATS Avalon beats; every output is registered.
// Optional stall watchdog enabled by defining MESM6_BRIDGE_TIMEOUT_EN.
module mesm6_avalon_bridge
    import mesm6_pkg::*;
#(
    parameter int  AV_DATA_W   = 32,
    parameter int  TIMEOUT_CYC = 1023,
    localparam int BEATS       = beats_for(AV_DATA_W),
    localparam int BW          = (BEATS > 1) ? $clog2(BEATS) : 1,
    localparam int AV_ADDR_W   = MESM_ADDR_W + BW
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [MESM_ADDR_W-1:0] mesm_addr,
    input  logic                   mesm_read,
    input  logic                   mesm_write,
    input  logic [MESM_WORD_W-1:0] mesm_wdata,
    output logic [MESM_WORD_W-1:0] mesm_rdata,
    output logic                   mesm_done,
    output logic                   mesm_error,
    output logic [AV_ADDR_W-1:0]   av_address,
    output logic                   av_read,
    output logic                   av_write,
    output logic [AV_DATA_W-1:0]   av_writedata,
    input  logic [AV_DATA_W-1:0]   av_readdata,
    input  logic                   av_waitrequest
);

    bridge_state_t          state_q, state_d;
    logic [BW-1:0]          beat_q, beat_d, beat_nxt;
    logic [MESM_ADDR_W-1:0] addr_q, addr_d;
    logic [MESM_WORD_W-1:0] wdata_q, wdata_d;
    logic                   is_wr_q, is_wr_d;
    logic                   av_read_q, av_read_d;
    logic                   av_write_q, av_write_d;
    logic [AV_ADDR_W-1:0]   av_addr_q, av_addr_d;
    logic [AV_DATA_W-1:0]   av_wdata_q, av_wdata_d;
    logic [MESM_WORD_W-1:0] rdata_q, rdata_d;
    logic                   done_q, done_d;

    // Beat b of the word, zero-filled above bit 47.
    function automatic logic [AV_DATA_W-1:0] beat_slice(input logic [MESM_WORD_W-1:0] w,
                                                        input logic [BW-1:0] b);
        logic [AV_DATA_W-1:0] s;
        int k;
        s = '0;
        for (int j = 0; j < AV_DATA_W; j++) begin
            k = int'(b) * AV_DATA_W + j;
            if (k < MESM_WORD_W) s[j] = w[k];
        end
        return s;
    endfunction

    // Drop beat b of readdata into the word; readdata bits above 47 fall away.
    function automatic logic [MESM_WORD_W-1:0] beat_merge(input logic [MESM_WORD_W-1:0] cur,
                                                         input logic [AV_DATA_W-1:0] rd,
                                                         input logic [BW-1:0] b);
        logic [MESM_WORD_W-1:0] w;
        w = cur;
        for (int i = 0; i < MESM_WORD_W; i++)
            if (i / AV_DATA_W == int'(b)) w[i] = rd[i % AV_DATA_W];
        return w;
    endfunction

    assign beat_nxt     = beat_q + BW'(1);
    assign mesm_rdata   = rdata_q;
    assign mesm_done    = done_q;
    assign av_address   = av_addr_q;
    assign av_read      = av_read_q;
    assign av_write     = av_write_q;
    assign av_writedata = av_wdata_q;

`ifdef MESM6_BRIDGE_TIMEOUT_EN
    logic wd_load, wd_expired;
    logic err_q, err_d;

    mesm6_bridge_wdog #(.LIMIT(TIMEOUT_CYC)) u_wdog (
        .clk       (clk),
        .rst_n     (reset_n),
        .load_i    (wd_load),
        .stall_i   ((state_q == ST_ACCESS) && av_waitrequest),
        .expired_o (wd_expired)
    );

    assign mesm_error = err_q;
`else
    assign mesm_error = 1'b0;
`endif

    // Next-state and registered-output logic; the Avalon command for the next
    // cycle is computed here so nothing combinational reaches the av_* outputs.
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        is_wr_d    = is_wr_q;
        av_read_d  = av_read_q;
        av_write_d = av_write_q;
        av_addr_d  = av_addr_q;
        av_wdata_d = av_wdata_q;
        rdata_d    = rdata_q;
        done_d     = 1'b0;
`ifdef MESM6_BRIDGE_TIMEOUT_EN
        err_d      = 1'b0;
        wd_load    = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (mesm_read || mesm_write) begin
                    state_d    = ST_ACCESS;
                    beat_d     = '0;
                    addr_d     = mesm_addr;
                    wdata_d    = mesm_wdata;
                    is_wr_d    = mesm_write;    // write wins when both are high
                    av_read_d  = !mesm_write;
                    av_write_d = mesm_write;
                    av_addr_d  = {mesm_addr, {BW{1'b0}}};
                    av_wdata_d = beat_slice(mesm_wdata, '0);
`ifdef MESM6_BRIDGE_TIMEOUT_EN
                    wd_load    = 1'b1;
`endif
                end
            end
            ST_ACCESS: begin
                if (!av_waitrequest) begin
                    if (!is_wr_q)
                        rdata_d = beat_merge(rdata_q, av_readdata, beat_q);
                    if (beat_q == BW'(BEATS - 1)) begin
                        state_d    = ST_DONE;
                        av_read_d  = 1'b0;
                        av_write_d = 1'b0;
                        done_d     = 1'b1;
                    end else begin
                        beat_d     = beat_nxt;
                        av_addr_d  = {addr_q, beat_nxt};
                        av_wdata_d = beat_slice(wdata_q, beat_nxt);
`ifdef MESM6_BRIDGE_TIMEOUT_EN
                        wd_load    = 1'b1;
`endif
                    end
                end
`ifdef MESM6_BRIDGE_TIMEOUT_EN
                else if (wd_expired) begin
                    state_d    = ST_DONE;
                    av_read_d  = 1'b0;
                    av_write_d = 1'b0;
                    done_d     = 1'b1;
                    err_d      = 1'b1;
                    if (!is_wr_q)
                        rdata_d = '1;
                end
`endif
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset drops any in-flight command at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            beat_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            is_wr_q    <= 1'b0;
            av_read_q  <= 1'b0;
            av_write_q <= 1'b0;
            av_addr_q  <= '0;
            av_wdata_q <= '0;
            rdata_q    <= '0;
            done_q     <= 1'b0;
`ifdef MESM6_BRIDGE_TIMEOUT_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            is_wr_q    <= is_wr_d;
            av_read_q  <= av_read_d;
            av_write_q <= av_write_d;
            av_addr_q  <= av_addr_d;
            av_wdata_q <= av_wdata_d;
            rdata_q    <= rdata_d;
            done_q     <= done_d;
`ifdef MESM6_BRIDGE_TIMEOUT_EN
            err_q      <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_mesm6_avalon_bridge.sv
// Bench for mesm6_avalon_bridge: 32-bit instance against a word-level memory
// model with a randomly stalling Avalon slave, plus 16- and 64-bit instances.
module tb_mesm6_avalon_bridge;

    localparam logic [47:0] ALL_ONES = 48'o7777777777777777;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    // 32-bit instance
    logic [14:0] m_addr;
    logic        m_rd, m_wr, m_done, m_err;
    logic [47:0] m_wdata, m_rdata;
    logic [15:0] a_addr;
    logic        a_rd, a_wr;
    logic [31:0] a_wdata;
    logic [31:0] a_rdata = '0;
    logic        a_wait  = 1'b0;

    mesm6_avalon_bridge #(.AV_DATA_W(32), .TIMEOUT_CYC(8)) dut32 (
        .clk(clk), .reset_n(reset_n),
        .mesm_addr(m_addr), .mesm_read(m_rd), .mesm_write(m_wr), .mesm_wdata(m_wdata),
        .mesm_rdata(m_rdata), .mesm_done(m_done), .mesm_error(m_err),
        .av_address(a_addr), .av_read(a_rd), .av_write(a_wr), .av_writedata(a_wdata),
        .av_readdata(a_rdata), .av_waitrequest(a_wait)
    );

    // 16-bit instance
    logic [14:0] mb_addr;
    logic        mb_rd, mb_wr, mb_done, mb_err;
    logic [47:0] mb_wdata, mb_rdata;
    logic [16:0] b_addr;
    logic        b_rd, b_wr, b_wait;
    logic [15:0] b_wdata, b_rdata;

    mesm6_avalon_bridge #(.AV_DATA_W(16)) dut16 (
        .clk(clk), .reset_n(reset_n),
        .mesm_addr(mb_addr), .mesm_read(mb_rd), .mesm_write(mb_wr), .mesm_wdata(mb_wdata),
        .mesm_rdata(mb_rdata), .mesm_done(mb_done), .mesm_error(mb_err),
        .av_address(b_addr), .av_read(b_rd), .av_write(b_wr), .av_writedata(b_wdata),
        .av_readdata(b_rdata), .av_waitrequest(b_wait)
    );

    // 64-bit instance
    logic [14:0] mc_addr;
    logic        mc_rd, mc_wr, mc_done, mc_err;
    logic [47:0] mc_wdata, mc_rdata;
    logic [15:0] c_addr;
    logic        c_rd, c_wr, c_wait;
    logic [63:0] c_wdata, c_rdata;

    mesm6_avalon_bridge #(.AV_DATA_W(64)) dut64 (
        .clk(clk), .reset_n(reset_n),
        .mesm_addr(mc_addr), .mesm_read(mc_rd), .mesm_write(mc_wr), .mesm_wdata(mc_wdata),
        .mesm_rdata(mc_rdata), .mesm_done(mc_done), .mesm_error(mc_err),
        .av_address(c_addr), .av_read(c_rd), .av_write(c_wr), .av_writedata(c_wdata),
        .av_readdata(c_rdata), .av_waitrequest(c_wait)
    );

    // Avalon slave behind the 32-bit bridge: beat-addressed RAM, random stalls
    // (capped at 4 in a row), forced stalls on beat 1, or stuck waitrequest.
    // Odd beats return junk in the upper half, which the bridge must drop.
    logic [31:0] smem [0:65535];
    int stall_pct   = 0;
    int stall_beat1 = 0;
    bit stuck       = 0;
    int stall_total = 0;
    int run         = 0;
    int b1cnt       = 0;

    always @(negedge clk) begin
        if (!(a_rd || a_wr)) begin
            a_wait = 1'b0;
            b1cnt  = 0;
        end else if (stuck) begin
            a_wait = 1'b1;
        end else if (a_addr[0] && b1cnt < stall_beat1) begin
            a_wait = 1'b1;
            b1cnt++;
        end else if (run < 4 && $urandom_range(0, 99) < stall_pct) begin
            a_wait = 1'b1;
        end else begin
            a_wait = 1'b0;
        end
        run = a_wait ? run + 1 : 0;
        if ((a_rd || a_wr) && a_wait) stall_total++;
        a_rdata = smem[a_addr] | (a_addr[0] ? {16'($urandom), 16'h0} : 32'h0);
        if (a_wr && !a_wait) smem[a_addr] = a_wdata;
    end

    // Word-level reference model
    logic [47:0] ref_mem [logic [14:0]];
    logic [47:0] last_rd = '0;

    task automatic access32(input bit rd, input bit wr, input logic [14:0] a,
                            input logic [47:0] wd, output int cyc_o);
        int cyc, s0;
        bit seen, held;
        logic [15:0] h_addr;
        logic [31:0] h_data;
        logic [1:0]  h_cmd;
        s0 = stall_total; seen = 0; held = 0; cyc = 0;
        h_addr = '0; h_data = '0; h_cmd = '0;
        m_addr = a; m_rd = rd; m_wr = wr; m_wdata = wd;
        while (!seen && cyc < 200) begin
            @(negedge clk); #1;
            cyc++;
            if (held) begin
                checks++;
                if ({a_addr, a_wdata, a_rd, a_wr} !== {h_addr, h_data, h_cmd}) begin
                    errors++;
                    $display("FAIL cmd_stable: got %h/%h/%b%b want %h/%h/%b", a_addr, a_wdata,
                             a_rd, a_wr, h_addr, h_data, h_cmd);
                end
            end
            held = (a_rd || a_wr) && a_wait;
            h_addr = a_addr; h_data = a_wdata; h_cmd = {a_rd, a_wr};
            if (m_done) seen = 1;
        end
        m_rd = 0; m_wr = 0;
        cyc_o = cyc;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL done_bound: no mesm_done within %0d cycles, addr %o", cyc, a);
            return;
        end
        checks++;
        if (cyc != 3 + (stall_total - s0)) begin
            errors++;
            $display("FAIL latency: got %0d want %0d", cyc, 3 + (stall_total - s0));
        end
        checks++;
        if (m_err !== 1'b0) begin
            errors++;
            $display("FAIL error_flag: got %b want 0", m_err);
        end
        checks++;
        if (wr) begin
            ref_mem[a] = wd;
            if (m_rdata !== last_rd) begin
                errors++;
                $display("FAIL rdata_hold: got %h want %h", m_rdata, last_rd);
            end
        end else begin
            if (m_rdata !== ref_mem[a]) begin
                errors++;
                $display("FAIL read_data addr %o: got %h want %h", a, m_rdata, ref_mem[a]);
            end
            last_rd = ref_mem[a];
        end
        @(negedge clk); #1;
        checks++;
        if (m_done !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: done still %b one cycle later", m_done);
        end
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        checks++;
        if ({a_rd, a_wr, m_done, m_err, a_addr, a_wdata, m_rdata} !== '0) begin
            errors++;
            $display("FAIL reset32: got %b%b%b%b %h %h %h want all 0", a_rd, a_wr, m_done, m_err,
                     a_addr, a_wdata, m_rdata);
        end
        checks++;
        if ({b_rd, b_wr, mb_done, mb_err, b_addr, b_wdata, mb_rdata,
             c_rd, c_wr, mc_done, mc_err, c_addr, c_wdata, mc_rdata} !== '0) begin
            errors++;
            $display("FAIL reset16_64: got %b%b %h %h %b%b %h %h want 0", b_rd, b_wr, b_addr,
                     mb_rdata, c_rd, c_wr, c_addr, mc_rdata);
        end
        reset_n = 1'b1;
        repeat (2) begin @(negedge clk); #1; end
        checks++;
        if ({a_rd, a_wr, m_done} !== 3'b000) begin
            errors++;
            $display("FAIL idle_after_reset: rd/wr/done %b%b%b want 000", a_rd, a_wr, m_done);
        end
    endtask

    task automatic test_write32();
        logic [47:0] wd;
        logic [14:0] a;
        wd = 48'o1234567012345670; a = 15'o4;
        stall_pct = 0;
        m_addr = a; m_wr = 1; m_rd = 0; m_wdata = wd;
        @(negedge clk); #1;
        checks++;
        if ({a_wr, a_rd, a_addr, a_wdata} !== {1'b1, 1'b0, a, 1'b0, wd[31:0]}) begin
            errors++;
            $display("FAIL wr32_beat0: got %b%b %h %h want 10 %h %h", a_wr, a_rd, a_addr, a_wdata,
                     {a, 1'b0}, wd[31:0]);
        end
        @(negedge clk); #1;
        checks++;
        if ({a_wr, a_addr, a_wdata} !== {1'b1, a, 1'b1, 16'h0, wd[47:32]}) begin
            errors++;
            $display("FAIL wr32_beat1: got %b %h %h want 1 %h %h", a_wr, a_addr, a_wdata,
                     {a, 1'b1}, {16'h0, wd[47:32]});
        end
        @(negedge clk); #1;
        checks++;
        if ({m_done, a_wr} !== 2'b10) begin
            errors++;
            $display("FAIL wr32_done_cycle3: done/wr got %b%b want 10", m_done, a_wr);
        end
        m_wr = 0;
        ref_mem[a] = wd;
        @(negedge clk); #1;
    endtask

    task automatic test_read_stall();
        int cyc;
        access32(0, 1, 15'o4, 48'hCAFEDEADBEEF, cyc);
        stall_beat1 = 2;
        access32(1, 0, 15'o4, '0, cyc);
        stall_beat1 = 0;
        checks++;
        if (cyc != 5 || m_rdata !== 48'hCAFEDEADBEEF) begin
            errors++;
            $display("FAIL rd_stall: done cycle %0d rdata %h want 5 cafedeadbeef", cyc, m_rdata);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        stall_beat1 = 10;
        m_addr = 15'o4; m_rd = 1; m_wr = 0;
        repeat (2) begin @(negedge clk); #1; end
        checks++;
        if (!(a_rd === 1'b1 && a_addr[0] === 1'b1 && a_wait === 1'b1)) begin
            errors++;
            $display("FAIL mid_setup: rd %b beat %b wait %b want 1 1 1", a_rd, a_addr[0], a_wait);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({a_rd, a_wr} !== 2'b00) begin
            errors++;
            $display("FAIL async_cmd_drop: rd/wr %b%b want 00", a_rd, a_wr);
        end
        checks++;
        if ({m_rdata, a_addr, a_wdata, m_done} !== '0) begin
            errors++;
            $display("FAIL async_clear: rdata %h addr %h wdata %h done %b want 0", m_rdata, a_addr,
                     a_wdata, m_done);
        end
        m_rd = 0; stall_beat1 = 0; last_rd = '0;
        @(negedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk); #1;
        checks++;
        if ({a_rd, a_wr, m_done} !== 3'b000 || m_rdata !== '0) begin
            errors++;
            $display("FAIL post_reset_idle: rd/wr/done %b%b%b rdata %h want 000 0", a_rd, a_wr,
                     m_done, m_rdata);
        end
        access32(1, 0, 15'o4, '0, cyc);
    endtask

    task automatic test_wide16();
        logic [47:0] wd;
        logic [14:0] a;
        wd = {16'($urandom), 32'($urandom)}; a = 15'($urandom);
        mb_addr = a; mb_wr = 1; mb_rd = 0; mb_wdata = wd;
        for (int b = 0; b < 3; b++) begin
            @(negedge clk); #1;
            checks++;
            if ({b_wr, b_rd, b_addr, b_wdata} !== {1'b1, 1'b0, a, 2'(b), wd[16*b +: 16]}) begin
                errors++;
                $display("FAIL w16_beat%0d: got %b%b %h %h want 10 %h %h", b, b_wr, b_rd, b_addr,
                         b_wdata, {a, 2'(b)}, wd[16*b +: 16]);
            end
        end
        @(negedge clk); #1;
        checks++;
        if ({mb_done, b_wr} !== 2'b10) begin
            errors++;
            $display("FAIL w16_done: done/wr %b%b want 10", mb_done, b_wr);
        end
        mb_wr = 0;
    endtask

    task automatic test_wide64();
        logic [14:0] a;
        a = 15'($urandom);
        c_rdata = {$urandom, $urandom};
        mc_addr = a; mc_rd = 1; mc_wr = 0;
        @(negedge clk); #1;
        checks++;
        if ({c_rd, c_wr, c_addr} !== {1'b1, 1'b0, a, 1'b0}) begin
            errors++;
            $display("FAIL r64_beat: got %b%b %h want 10 %h", c_rd, c_wr, c_addr, {a, 1'b0});
        end
        @(negedge clk); #1;
        checks++;
        if (mc_done !== 1'b1 || mc_rdata !== c_rdata[47:0]) begin
            errors++;
            $display("FAIL r64_data: done %b rdata %h want 1 %h", mc_done, mc_rdata, c_rdata[47:0]);
        end
        mc_rd = 0;
    endtask

    task automatic test_random();
        logic [14:0] addrs [8];
        int cyc, op;
        stall_pct = 25;
        for (int i = 0; i < 8; i++) begin
            addrs[i] = 15'($urandom);
            access32(0, 1, addrs[i], {16'($urandom), 32'($urandom)}, cyc);
        end
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 2);
            access32(op != 1, op != 0, addrs[$urandom_range(0, 7)],
                     {16'($urandom), 32'($urandom)}, cyc);
        end
        stall_pct = 0;
    endtask

    task automatic test_back_to_back();
        int d1, d2, cyc;
        d1 = 0; d2 = 0; cyc = 0;
        m_addr = 15'o4; m_rd = 1; m_wr = 0;
        while (d2 == 0 && cyc < 40) begin
            @(negedge clk); #1;
            cyc++;
            if (m_done) begin
                if (d1 == 0) d1 = cyc;
                else d2 = cyc;
            end
        end
        m_rd = 0;
        checks++;
        if (d1 != 3 || d2 != 7) begin
            errors++;
            $display("FAIL back_to_back: done cycles %0d,%0d want 3,7", d1, d2);
        end
        checks++;
        if (m_rdata !== ref_mem[15'o4]) begin
            errors++;
            $display("FAIL b2b_data: got %h want %h", m_rdata, ref_mem[15'o4]);
        end
        last_rd = ref_mem[15'o4];
        @(negedge clk); #1;
    endtask

    task automatic test_both();
        int cyc;
        logic [14:0] a;
        a = 15'o7;
        access32(1, 1, a, {16'($urandom), 32'($urandom)}, cyc);
        access32(1, 0, a, '0, cyc);
    endtask

`ifdef MESM6_BRIDGE_TIMEOUT_EN
    task automatic test_timeout();
        int cyc, rd_cyc;
        bit seen;
        cyc = 0; rd_cyc = 0; seen = 0;
        stuck = 1;
        m_addr = 15'o4; m_rd = 1; m_wr = 0;
        while (!seen && cyc < 40) begin
            @(negedge clk); #1;
            cyc++;
            if (a_rd) rd_cyc++;
            if (m_done) seen = 1;
        end
        m_rd = 0;
        stuck = 0;
        checks++;
        if (!seen || rd_cyc != 8 || cyc != 9) begin
            errors++;
            $display("FAIL timeout_len: seen %b cmd cycles %0d done cycle %0d want 1 8 9", seen,
                     rd_cyc, cyc);
        end
        checks++;
        if (m_err !== 1'b1 || m_rdata !== ALL_ONES) begin
            errors++;
            $display("FAIL timeout_result: err %b rdata %h want 1 %h", m_err, m_rdata, ALL_ONES);
        end
        last_rd = ALL_ONES;
        @(negedge clk); #1;
        checks++;
        if ({m_done, m_err, a_rd} !== 3'b000) begin
            errors++;
            $display("FAIL timeout_pulse: done/err/rd %b%b%b want 000", m_done, m_err, a_rd);
        end
    endtask
`endif

    initial begin
        reset_n = 1'b0;
        m_addr = '0; m_rd = 0; m_wr = 0; m_wdata = '0;
        mb_addr = '0; mb_rd = 0; mb_wr = 0; mb_wdata = '0; b_rdata = '0; b_wait = 0;
        mc_addr = '0; mc_rd = 0; mc_wr = 0; mc_wdata = '0; c_rdata = '0; c_wait = 0;
        test_reset();
        test_write32();
        test_read_stall();
        test_reset_mid();
        test_wide16();
        test_wide64();
        test_random();
        test_back_to_back();
        test_both();
`ifdef MESM6_BRIDGE_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, %0d checks so far", checks);
        $fatal(1, "global time limit reached");
    end

endmodule
